// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Define MULDIV_EARLY_OUT_EN to let zero-operand cases skip the iteration phase.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_MULH = 2'd1,
    MD_DIV  = 2'd2,
    MD_REM  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  localparam logic [31:0] DIV_BY_ZERO_QUO = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_DIVIDEND    = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR     = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUO         = 32'h8000_0000;
  localparam logic [31:0] OVF_REM         = 32'h0000_0000;

  // Magnitude of a two's complement value; 0x80000000 maps to itself as unsigned 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage (master) and the
// multiply/divide sequencer (slave).
interface muldiv_if;
  import muldiv_pkg::*;

  logic        i_req_valid;
  muldiv_op_t  i_req_op;
  logic [3:0]  i_req_rd;
  logic [31:0] i_req_a;
  logic [31:0] i_req_b;
  logic        i_flush;
  logic        o_stall;
  logic        o_done;
  logic [3:0]  o_res_rd;
  logic [31:0] o_res_val;
  logic [31:0] o_busy_cycles;

  modport master (
    output i_req_valid, i_req_op, i_req_rd, i_req_a, i_req_b, i_flush,
    input  o_stall, o_done, o_res_rd, o_res_val, o_busy_cycles
  );

  modport slave (
    input  i_req_valid, i_req_op, i_req_rd, i_req_a, i_req_b, i_flush,
    output o_stall, o_done, o_res_rd, o_res_val, o_busy_cycles
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational radix-2 step: shift-add for multiply (acc:shreg shift right),
// restoring shift-subtract for divide (acc = remainder, shreg = dividend/quotient).
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        div_sel,
  input  logic [31:0] acc,
  input  logic [31:0] shreg,
  input  logic [31:0] operand,
  output logic [31:0] acc_step,
  output logic [31:0] shreg_step
);

  logic [32:0] sum;
  logic [32:0] trial;

  always_comb begin
    sum        = {1'b0, acc} + {1'b0, operand};
    // Remainder stays below the divisor, so bit 32 of the trial is a clean borrow flag.
    trial      = {acc, shreg[31]} - {1'b0, operand};
    acc_step   = '0;
    shreg_step = '0;
    if (div_sel) begin
      if (!trial[32]) begin
        acc_step   = trial[31:0];
        shreg_step = {shreg[30:0], 1'b1};
      end else begin
        acc_step   = {acc[30:0], shreg[31]};
        shreg_step = {shreg[30:0], 1'b0};
      end
    end else begin
      if (shreg[0]) begin
        acc_step   = sum[32:1];
        shreg_step = {sum[0], shreg[31:1]};
      end else begin
        acc_step   = {1'b0, acc[31:1]};
        shreg_step = {acc[0], shreg[31:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MUL/MULH/DIV/REM sequencer that stalls execute until its result is ready.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero skip RUN.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int STEPS = 1
) (
  input  logic    i_clk,
  input  logic    i_reset_n,
  muldiv_if.slave bus
);

  localparam logic [5:0] RUN_LOAD = 6'(32 / STEPS);

  state_t      state_reg, state_next;
  logic [5:0]  count_reg, count_next;
  muldiv_op_t  op_reg, op_next;
  logic [3:0]  rd_reg, rd_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic        div_sel_reg, div_sel_next;
  logic [31:0] acc_reg, acc_next;
  logic [31:0] shreg_reg, shreg_next;
  logic [31:0] operand_reg, operand_next;
  logic [3:0]  res_rd_reg, res_rd_next;
  logic [31:0] res_val_reg, res_val_next;
  logic [31:0] busy_reg, busy_next;

  logic        stall;
  logic        req_div;
  logic        early_out;
  logic [31:0] acc_run, shreg_run;
  logic [63:0] prod_abs, prod_signed;
  logic [31:0] quo_signed, rem_signed, fix_val;
  logic        b_zero, ovf_case;

  // STEPS radix-2 stages chained back to back, one pass per RUN cycle.
  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    logic [31:0] acc_in, shreg_in, acc_out, shreg_out;
    if (gi == 0) begin : g_first
      assign acc_in   = acc_reg;
      assign shreg_in = shreg_reg;
    end else begin : g_chain
      assign acc_in   = g_step[gi-1].acc_out;
      assign shreg_in = g_step[gi-1].shreg_out;
    end
    muldiv_step u_step (
      .div_sel    (div_sel_reg),
      .acc        (acc_in),
      .shreg      (shreg_in),
      .operand    (operand_reg),
      .acc_step   (acc_out),
      .shreg_step (shreg_out)
    );
  end

  assign acc_run   = g_step[STEPS-1].acc_out;
  assign shreg_run = g_step[STEPS-1].shreg_out;

  always_comb begin
    prod_abs    = {acc_reg, shreg_reg};
    prod_signed = (a_reg[31] ^ b_reg[31]) ? (~prod_abs + 64'd1) : prod_abs;
    quo_signed  = (a_reg[31] ^ b_reg[31]) ? (~shreg_reg + 32'd1) : shreg_reg;
    rem_signed  = a_reg[31] ? (~acc_reg + 32'd1) : acc_reg;
    b_zero      = (b_reg == '0);
    ovf_case    = (a_reg == OVF_DIVIDEND) && (b_reg == OVF_DIVISOR);
    fix_val     = '0;
    case (op_reg)
      MD_MUL:  fix_val = prod_signed[31:0];
      MD_MULH: fix_val = prod_signed[63:32];
      MD_DIV:  fix_val = b_zero ? DIV_BY_ZERO_QUO : (ovf_case ? OVF_QUO : quo_signed);
      MD_REM:  fix_val = b_zero ? a_reg : (ovf_case ? OVF_REM : rem_signed);
      default: fix_val = '0;
    endcase
  end

  always_comb begin
    req_div = (bus.i_req_op == MD_DIV) || (bus.i_req_op == MD_REM);
`ifdef MULDIV_EARLY_OUT_EN
    early_out = req_div ? (bus.i_req_b == '0)
                        : ((bus.i_req_a == '0) || (bus.i_req_b == '0));
`else
    early_out = 1'b0;
`endif
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    op_next      = op_reg;
    rd_next      = rd_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    div_sel_next = div_sel_reg;
    acc_next     = acc_reg;
    shreg_next   = shreg_reg;
    operand_next = operand_reg;
    res_rd_next  = res_rd_reg;
    res_val_next = res_val_reg;
    stall        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.i_req_valid && !bus.i_flush) begin
          stall        = 1'b1;
          state_next   = early_out ? FIX : RUN;
          count_next   = RUN_LOAD;
          op_next      = bus.i_req_op;
          rd_next      = bus.i_req_rd;
          a_next       = bus.i_req_a;
          b_next       = bus.i_req_b;
          div_sel_next = req_div;
          acc_next     = '0;
          // Divide shifts the dividend out of shreg; multiply shifts the multiplier.
          shreg_next   = req_div ? abs32(bus.i_req_a) : abs32(bus.i_req_b);
          operand_next = req_div ? abs32(bus.i_req_b) : abs32(bus.i_req_a);
          if (early_out && !req_div) begin
            shreg_next = '0;
          end
        end
      end
      RUN: begin
        stall      = 1'b1;
        acc_next   = acc_run;
        shreg_next = shreg_run;
        count_next = count_reg - 6'd1;
        if (count_reg == 6'd1) begin
          state_next = FIX;
        end
      end
      FIX: begin
        stall        = 1'b1;
        res_val_next = fix_val;
        res_rd_next  = rd_reg;
        state_next   = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (bus.i_flush) begin
      state_next   = IDLE;
      res_val_next = res_val_reg;
      res_rd_next  = res_rd_reg;
    end
  end

  assign busy_next = busy_reg + {31'd0, stall};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      op_reg      <= MD_MUL;
      rd_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      div_sel_reg <= 1'b0;
      acc_reg     <= '0;
      shreg_reg   <= '0;
      operand_reg <= '0;
      res_rd_reg  <= '0;
      res_val_reg <= '0;
      busy_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      op_reg      <= op_next;
      rd_reg      <= rd_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      div_sel_reg <= div_sel_next;
      acc_reg     <= acc_next;
      shreg_reg   <= shreg_next;
      operand_reg <= operand_next;
      res_rd_reg  <= res_rd_next;
      res_val_reg <= res_val_next;
      busy_reg    <= busy_next;
    end
  end

  // Reset forces the stall low at once even if execute is still presenting a request.
  assign bus.o_stall       = stall && i_reset_n;
  assign bus.o_done        = (state_reg == DONE) && !bus.i_flush;
  assign bus.o_res_rd      = res_rd_reg;
  assign bus.o_res_val     = res_val_reg;
  assign bus.o_busy_cycles = busy_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench running three sequencers side by side (STEPS = 1, 2, 4)
// on identical operations, checking results, latency, stall length, flush and reset.
module tb_muldiv_seq;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [2:0]  valid;
  logic [2:0]  flush;
  muldiv_op_t  op;
  logic [3:0]  rd;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  stall;
  logic [2:0]  done;
  logic [3:0]  res_rd  [3];
  logic [31:0] res_val [3];
  logic [31:0] busy    [3];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    muldiv_if bus_if ();
    assign bus_if.i_req_valid = valid[gi];
    assign bus_if.i_req_op    = op;
    assign bus_if.i_req_rd    = rd;
    assign bus_if.i_req_a     = a;
    assign bus_if.i_req_b     = b;
    assign bus_if.i_flush     = flush[gi];
    assign stall[gi]          = bus_if.o_stall;
    assign done[gi]           = bus_if.o_done;
    assign res_rd[gi]         = bus_if.o_res_rd;
    assign res_val[gi]        = bus_if.o_res_val;
    assign busy[gi]           = bus_if.o_busy_cycles;
    muldiv_seq #(.STEPS(1 << gi)) u_dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus_if)
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int exp_latency(input int j, input muldiv_op_t t_op,
                                     input logic [31:0] t_a, input logic [31:0] t_b);
    int n;
    n = (32 >> j) + 2;
    if (EARLY_EN) begin
      if (t_op == MD_DIV || t_op == MD_REM) begin
        if (t_b == 32'd0) n = 2;
      end else if (t_a == 32'd0 || t_b == 32'd0) begin
        n = 2;
      end
    end
    return n;
  endfunction

  // Present one request to all three units, hold it until each reports done.
  task automatic run_op(input string name, input muldiv_op_t t_op, input logic [31:0] t_a,
                        input logic [31:0] t_b, input logic [3:0] t_rd, input logic [31:0] exp);
    int          lat [3];
    int          stl [3];
    logic [31:0] got [3];
    logic [3:0]  grd [3];
    bit          fin [3];
    int          el;
    @(negedge clk);
    op = t_op; a = t_a; b = t_b; rd = t_rd; valid = 3'b111;
    for (int j = 0; j < 3; j++) begin
      lat[j] = 0; stl[j] = 0; got[j] = '0; grd[j] = '0; fin[j] = 1'b0;
    end
    #1;
    for (int j = 0; j < 3; j++) if (stall[j]) stl[j] = 1;
    for (int k = 1; k <= 60; k++) begin
      if (fin[0] && fin[1] && fin[2]) break;
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        if (!fin[j]) begin
          if (done[j]) begin
            lat[j] = k; got[j] = res_val[j]; grd[j] = res_rd[j]; fin[j] = 1'b1;
            valid[j] = 1'b0;
            check_eq($sformatf("%s_stall_at_done_s%0d", name, 1 << j), {31'd0, stall[j]}, 32'd0);
          end else if (stall[j]) begin
            stl[j]++;
          end
        end
      end
    end
    valid = 3'b000;
    for (int j = 0; j < 3; j++) begin
      el = exp_latency(j, t_op, t_a, t_b);
      $display("op %s steps=%0d a=%08h b=%08h -> val=%08h rd=%0d lat=%0d stall=%0d",
               name, 1 << j, t_a, t_b, got[j], grd[j], lat[j], stl[j]);
      check_eq($sformatf("%s_val_s%0d", name, 1 << j), got[j], exp);
      check_eq($sformatf("%s_rd_s%0d", name, 1 << j), {28'd0, grd[j]}, {28'd0, t_rd});
      check_eq($sformatf("%s_lat_s%0d", name, 1 << j), 32'(lat[j]), 32'(el));
      check_eq($sformatf("%s_stall_s%0d", name, 1 << j), 32'(stl[j]), 32'(el));
    end
  endtask

  // DIV aborted by flush, then MUL 3*4 accepted in the cycle after the longest flush.
  task automatic flush_test();
    int fc  [3];
    bit saw [3];
    int lat [3];
    logic [31:0] got [3];
    logic [31:0] bz  [3];
    bit fin [3];
    @(negedge clk);
    op = MD_DIV; a = 32'd100; b = 32'd7; rd = 4'd3; valid = 3'b111;
    for (int j = 0; j < 3; j++) begin
      fc[j]  = ((32 >> j) >= 10) ? 10 : 5;
      saw[j] = 1'b0; lat[j] = 0; got[j] = '0; bz[j] = '0; fin[j] = 1'b0;
    end
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        if (done[j]) saw[j] = 1'b1;
        flush[j] = (k == fc[j]);
        if (k == fc[j]) valid[j] = 1'b0;
      end
    end
    for (int j = 0; j < 3; j++)
      check_eq($sformatf("flush_no_done_s%0d", 1 << j), {31'd0, saw[j]}, 32'd0);
    op = MD_MUL; a = 32'd3; b = 32'd4; rd = 4'd9; valid = 3'b111;
    for (int k = 1; k <= 60; k++) begin
      if (fin[0] && fin[1] && fin[2]) break;
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        if (!fin[j] && done[j]) begin
          lat[j] = k; got[j] = res_val[j]; bz[j] = busy[j]; fin[j] = 1'b1; valid[j] = 1'b0;
        end
      end
    end
    valid = 3'b000;
    for (int j = 0; j < 3; j++) begin
      $display("flush steps=%0d flush_cycle=%0d -> mul val=%08h lat=%0d busy=%0d",
               1 << j, fc[j], got[j], lat[j], bz[j]);
      check_eq($sformatf("flush_mul_val_s%0d", 1 << j), got[j], 32'd12);
      check_eq($sformatf("flush_mul_lat_s%0d", 1 << j), 32'(lat[j]), 32'((32 >> j) + 2));
      check_eq($sformatf("flush_busy_s%0d", 1 << j), bz[j], 32'(fc[j] + 1 + (32 >> j) + 2));
    end
  endtask

  initial begin
    rst_n = 1'b0; valid = 3'b000; flush = 3'b000;
    op = MD_MUL; a = '0; b = '0; rd = '0;
    repeat (3) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      check_eq($sformatf("rst_stall_s%0d", 1 << j), {31'd0, stall[j]}, 32'd0);
      check_eq($sformatf("rst_done_s%0d", 1 << j), {31'd0, done[j]}, 32'd0);
      check_eq($sformatf("rst_rd_s%0d", 1 << j), {28'd0, res_rd[j]}, 32'd0);
      check_eq($sformatf("rst_val_s%0d", 1 << j), res_val[j], 32'd0);
      check_eq($sformatf("rst_busy_s%0d", 1 << j), busy[j], 32'd0);
    end
    rst_n = 1'b1;

    flush_test();

    run_op("mul_7_m3",    MD_MUL,  32'd7,          32'hFFFF_FFFD, 4'd5,  32'hFFFF_FFEB);
    run_op("mulh_7_m3",   MD_MULH, 32'd7,          32'hFFFF_FFFD, 4'd6,  32'hFFFF_FFFF);
    run_op("mulh_min2",   MD_MULH, 32'h8000_0000,  32'h8000_0000, 4'd1,  32'h4000_0000);
    run_op("mul_min2",    MD_MUL,  32'h8000_0000,  32'h8000_0000, 4'd2,  32'h0000_0000);
    run_op("mul_m1m1",    MD_MUL,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 4'd7,  32'h0000_0001);
    run_op("mulh_m1m1",   MD_MULH, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 4'd8,  32'h0000_0000);
    run_op("mul_2p32",    MD_MUL,  32'h0001_0000,  32'h0001_0000, 4'd10, 32'h0000_0000);
    run_op("mulh_2p32",   MD_MULH, 32'h0001_0000,  32'h0001_0000, 4'd11, 32'h0000_0001);
    run_op("mul_zero_a",  MD_MUL,  32'd0,          32'd9,         4'd12, 32'h0000_0000);
    run_op("mulh_zero_b", MD_MULH, 32'hFFFF_FFF0,  32'd0,         4'd13, 32'h0000_0000);
    run_op("div_m7_2",    MD_DIV,  32'hFFFF_FFF9,  32'd2,         4'd14, 32'hFFFF_FFFD);
    run_op("rem_m7_2",    MD_REM,  32'hFFFF_FFF9,  32'd2,         4'd15, 32'hFFFF_FFFF);
    run_op("div_100_m7",  MD_DIV,  32'd100,        32'hFFFF_FFF9, 4'd4,  32'hFFFF_FFF2);
    run_op("rem_100_m7",  MD_REM,  32'd100,        32'hFFFF_FFF9, 4'd3,  32'h0000_0002);
    run_op("div_5_0",     MD_DIV,  32'd5,          32'd0,         4'd1,  32'hFFFF_FFFF);
    run_op("rem_5_0",     MD_REM,  32'd5,          32'd0,         4'd2,  32'h0000_0005);
    run_op("rem_m100_0",  MD_REM,  32'hFFFF_FF9C,  32'd0,         4'd3,  32'hFFFF_FF9C);
    run_op("div_ovf",     MD_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 4'd4,  32'h8000_0000);
    run_op("rem_ovf",     MD_REM,  32'h8000_0000,  32'hFFFF_FFFF, 4'd5,  32'h0000_0000);
    run_op("div_min_1",   MD_DIV,  32'h8000_0000,  32'd1,         4'd6,  32'h8000_0000);
    run_op("div_m1_max",  MD_DIV,  32'hFFFF_FFFF,  32'h7FFF_FFFF, 4'd7,  32'h0000_0000);
    run_op("rem_m1_max",  MD_REM,  32'hFFFF_FFFF,  32'h7FFF_FFFF, 4'd8,  32'hFFFF_FFFF);

    // Asynchronous reset in the middle of RUN, with the request still presented.
    @(negedge clk);
    op = MD_DIV; a = 32'd1000; b = 32'd3; rd = 4'd9; valid = 3'b111;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      $display("reset mid-run steps=%0d -> stall=%0d done=%0d val=%08h busy=%0d",
               1 << j, stall[j], done[j], res_val[j], busy[j]);
      check_eq($sformatf("midrst_stall_s%0d", 1 << j), {31'd0, stall[j]}, 32'd0);
      check_eq($sformatf("midrst_done_s%0d", 1 << j), {31'd0, done[j]}, 32'd0);
      check_eq($sformatf("midrst_val_s%0d", 1 << j), res_val[j], 32'd0);
      check_eq($sformatf("midrst_busy_s%0d", 1 << j), busy[j], 32'd0);
    end
    valid = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
